// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - fetches opcode/immediate words from program memory and issues them to a processor
// Optional build macro PROGRAM_SEQUENCER_HALT_ON_WRAP_EN: halt at the first completion after the PC wraps.
module program_sequencer #(
    parameter int INSTRUCTION_WIDTH = 9,
    parameter int ADDR_WIDTH        = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stop,
    output logic                         mem_rd,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic [INSTRUCTION_WIDTH-1:0] mem_data,
    output logic [INSTRUCTION_WIDTH-1:0] proc_din,
    output logic                         proc_run,
    input  logic                         proc_done,
    output logic [ADDR_WIDTH-1:0]        pc,
    output logic                         busy,
    output logic                         halted,
    output logic                         error
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH_OP, S_LATCH_OP, S_FETCH_IMM, S_LATCH_IMM,
        S_ISSUE, S_EXEC, S_HALTED, S_ERROR
    } state_t;

    localparam logic [2:0] OPC_MVI  = 3'b001;
    localparam logic [2:0] OPC_HALT = 3'b111;
    localparam logic [2:0] TMO_LAST = 3'd3;

    state_t                         state_q, state_d;
    logic [ADDR_WIDTH-1:0]          pc_q, pc_d;
    logic [INSTRUCTION_WIDTH-1:0]   op_q, op_d, imm_q, imm_d;
    logic [2:0]                     tmo_q, tmo_d;
    logic [INSTRUCTION_WIDTH-1:0]   proc_din_q, proc_din_d;
    logic                           mem_rd_q, proc_run_q, busy_q, halted_q, error_q;
    logic [2:0]                     mem_opc, op_opc_d;
    logic                           wrap_hit;

`ifdef PROGRAM_SEQUENCER_HALT_ON_WRAP_EN
    logic wrap_q, wrap_d;
    assign wrap_hit = wrap_q;
`else
    assign wrap_hit = 1'b0;
`endif

    assign mem_opc  = mem_data[INSTRUCTION_WIDTH-1 -: 3];
    assign op_opc_d = op_d[INSTRUCTION_WIDTH-1 -: 3];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        op_d    = op_q;
        imm_d   = imm_q;
        tmo_d   = tmo_q;
`ifdef PROGRAM_SEQUENCER_HALT_ON_WRAP_EN
        wrap_d  = wrap_q;
`endif
        case (state_q)
            S_IDLE:      if (start && !stop) state_d = S_FETCH_OP;
            S_FETCH_OP:  state_d = S_LATCH_OP;
            S_LATCH_OP: begin
                op_d = mem_data;
                pc_d = pc_q + ADDR_WIDTH'(1);
`ifdef PROGRAM_SEQUENCER_HALT_ON_WRAP_EN
                if (&pc_q) wrap_d = 1'b1;
`endif
                if (mem_opc == OPC_HALT)     state_d = S_HALTED;
                else if (mem_opc == OPC_MVI) state_d = S_FETCH_IMM;
                else                         state_d = S_ISSUE;
            end
            S_FETCH_IMM: state_d = S_LATCH_IMM;
            S_LATCH_IMM: begin
                imm_d   = mem_data;
                pc_d    = pc_q + ADDR_WIDTH'(1);
`ifdef PROGRAM_SEQUENCER_HALT_ON_WRAP_EN
                if (&pc_q) wrap_d = 1'b1;
`endif
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                tmo_d   = 3'd0;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // completion wins over the timeout on the same cycle
                if (proc_done) begin
                    if (wrap_hit)  state_d = S_HALTED;
                    else if (stop) state_d = S_IDLE;
                    else           state_d = S_FETCH_OP;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + 3'd1;
                end
            end
            S_HALTED, S_ERROR: state_d = state_q;
            default:           state_d = S_IDLE;
        endcase
    end

    always_comb begin
        proc_din_d = '0;
        if (state_d == S_ISSUE)                               proc_din_d = op_d;
        else if (state_d == S_EXEC && op_opc_d == OPC_MVI)    proc_din_d = imm_d;
    end

    // outputs are registered from the next state so they line up with state_q
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            op_q       <= '0;
            imm_q      <= '0;
            tmo_q      <= 3'd0;
            mem_rd_q   <= 1'b0;
            proc_run_q <= 1'b0;
            proc_din_q <= '0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
            error_q    <= 1'b0;
`ifdef PROGRAM_SEQUENCER_HALT_ON_WRAP_EN
            wrap_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            op_q       <= op_d;
            imm_q      <= imm_d;
            tmo_q      <= tmo_d;
            mem_rd_q   <= (state_d == S_FETCH_OP) || (state_d == S_FETCH_IMM);
            proc_run_q <= (state_d == S_ISSUE);
            proc_din_q <= proc_din_d;
            busy_q     <= state_d inside {S_FETCH_OP, S_LATCH_OP, S_FETCH_IMM,
                                          S_LATCH_IMM, S_ISSUE, S_EXEC};
            halted_q   <= (state_d == S_HALTED);
            error_q    <= (state_d == S_ERROR);
`ifdef PROGRAM_SEQUENCER_HALT_ON_WRAP_EN
            wrap_q     <= wrap_d;
`endif
        end
    end

    assign mem_rd   = mem_rd_q;
    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign proc_run = proc_run_q;
    assign proc_din = proc_din_q;
    assign busy     = busy_q;
    assign halted   = halted_q;
    assign error    = error_q;
endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - directed-trace bench for program_sequencer
// A program-level model expands each instruction into its expected per-cycle trace.
module tb_program_sequencer;
    localparam int IW = 9;
    localparam int AW = 5;
    localparam int DEPTH = 1 << AW;
    localparam logic [IW-1:0] JUNK = 9'h1C7;
    localparam int R_NEXT = 0, R_IDLE = 1, R_HALT = 2, R_ERR = 3, R_ABORT = 4;

    logic clk = 1'b0;
    logic rst, start, stop, proc_done, mem_rd, proc_run, busy, halted, error;
    logic [AW-1:0] mem_addr, pc;
    logic [IW-1:0] mem_data, proc_din;

    program_sequencer #(.INSTRUCTION_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .proc_din(proc_din), .proc_run(proc_run), .proc_done(proc_done),
        .pc(pc), .busy(busy), .halted(halted), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst, start, stop, done;
        logic [IW-1:0] mdata;
        logic rd;
        logic [AW-1:0] addr;
        logic run;
        logic [IW-1:0] din;
        logic busy, halted, error;
        bit ck;
    } cyc_t;

    cyc_t tr[$];
    logic [IW-1:0] mem [DEPTH];
    int m_pc = 0;
    bit m_wrap = 1'b0;
    int total = 0;
    int bad = 0;
    int cur = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cur, act, exp);
        end
    endtask

    function automatic void push(logic r, logic st, logic sp, logic dn, logic [IW-1:0] md,
                                 logic rd, logic run, logic [IW-1:0] din,
                                 logic bz, logic hl, logic er, bit ck);
        cyc_t c;
        c.rst = r; c.start = st; c.stop = sp; c.done = dn; c.mdata = md;
        c.rd = rd; c.addr = AW'(m_pc); c.run = run; c.din = din;
        c.busy = bz; c.halted = hl; c.error = er; c.ck = ck;
        tr.push_back(c);
    endfunction

    function automatic void adv();
`ifdef PROGRAM_SEQUENCER_HALT_ON_WRAP_EN
        if (m_pc == DEPTH - 1) m_wrap = 1'b1;
`endif
        m_pc = (m_pc + 1) % DEPTH;
    endfunction

    function automatic void gen_reset();
        push(1, 0, 0, 0, JUNK, 0, 0, '0, 0, 0, 0, 0);
        m_pc = 0;
        m_wrap = 1'b0;
        push(1, 0, 0, 0, JUNK, 0, 0, '0, 0, 0, 0, 1);
    endfunction

    function automatic void gen_idle(int n, logic st, logic sp);
        for (int k = 0; k < n; k++) push(0, st, sp, 0, JUNK, 0, 0, '0, 0, 0, 0, 1);
    endfunction

    function automatic void gen_term(int n, logic hl, logic st, logic sp);
        for (int k = 0; k < n; k++) push(0, st, sp, 1, JUNK, 0, 0, '0, 0, hl, !hl, 1);
    endfunction

    // lat: EXEC cycle carrying proc_done (>4 never completes); sp: stop level from issue on;
    // stray: stop/done noise during fetch; abort_k: EXEC cycle that gets rst.
    function automatic int gen_instr(int lat, logic sp, logic stray, int abort_k);
        logic [IW-1:0] word, imm;
        logic [2:0] opc;
        word = mem[m_pc];
        opc  = word[IW-1 -: 3];
        imm  = '0;
        push(0, 0, stray, stray, JUNK, 1, 0, '0, 1, 0, 0, 1);
        push(0, 0, stray, stray, word, 0, 0, '0, 1, 0, 0, 1);
        adv();
        if (opc == 3'b111) return R_HALT;
        if (opc == 3'b001) begin
            imm = mem[m_pc];
            push(0, 0, stray, stray, JUNK, 1, 0, '0, 1, 0, 0, 1);
            push(0, 0, stray, stray, imm, 0, 0, '0, 1, 0, 0, 1);
            adv();
        end
        push(0, 0, sp, stray, JUNK, 0, 1, word, 1, 0, 0, 1);
        for (int k = 1; k <= 4; k++) begin
            push(k == abort_k, 0, sp, k == lat, JUNK, 0, 0, (opc == 3'b001) ? imm : '0, 1, 0, 0, 1);
            if (k == abort_k) begin
                m_pc = 0;
                m_wrap = 1'b0;
                return R_ABORT;
            end
            if (k == lat) begin
                if (m_wrap) return R_HALT;
                return sp ? R_IDLE : R_NEXT;
            end
        end
        return R_ERR;
    endfunction

    always @(negedge clk) begin
        if (cmp_en && tr[cur].ck) begin
            chk("mem_rd",   32'(mem_rd),   32'(tr[cur].rd));
            chk("mem_addr", 32'(mem_addr), 32'(tr[cur].addr));
            chk("pc",       32'(pc),       32'(tr[cur].addr));
            chk("proc_run", 32'(proc_run), 32'(tr[cur].run));
            chk("proc_din", 32'(proc_din), 32'(tr[cur].din));
            chk("busy",     32'(busy),     32'(tr[cur].busy));
            chk("halted",   32'(halted),   32'(tr[cur].halted));
            chk("error",    32'(error),    32'(tr[cur].error));
        end
    end

    initial begin
        int r, p_s1, p_halt, p_mvi, p_err, p_rst, p_wrap;
        rst = 1'b1; start = 1'b0; stop = 1'b0; proc_done = 1'b0; mem_data = JUNK;
        for (int a = 0; a < DEPTH; a++) mem[a] = JUNK;

        // mv, mv with noise, HALT
        gen_reset();
        gen_idle(2, 0, 0);
        mem[0] = 9'h00A; mem[1] = 9'h011; mem[2] = 9'h1C0;
        p_s1 = tr.size();
        gen_idle(1, 1, 0);
        r = gen_instr(1, 0, 0, 0); chk("model_mv0", 32'(r), R_NEXT);
        r = gen_instr(1, 0, 1, 0); chk("model_mv1", 32'(r), R_NEXT);
        r = gen_instr(1, 0, 0, 0); chk("model_halt", 32'(r), R_HALT);
        p_halt = tr.size();
        gen_term(2, 1, 1, 0);
        gen_term(2, 1, 0, 1);

        // mvi, add, sub with stop, start+stop, op 100 done at timeout edge, hang
        gen_reset();
        mem[0] = 9'h040; mem[1] = 9'h05A; mem[2] = 9'h080; mem[3] = 9'h0C0;
        mem[4] = 9'h105; mem[5] = 9'h080;
        gen_idle(1, 1, 0);
        p_mvi = tr.size();
        r = gen_instr(1, 0, 0, 0); chk("model_mvi", 32'(r), R_NEXT);
        r = gen_instr(3, 0, 0, 0); chk("model_add", 32'(r), R_NEXT);
        r = gen_instr(3, 1, 0, 0); chk("model_sub_stop", 32'(r), R_IDLE);
        gen_idle(3, 1, 1);
        gen_idle(1, 1, 0);
        r = gen_instr(4, 0, 0, 0); chk("model_op100", 32'(r), R_NEXT);
        r = gen_instr(9, 0, 0, 0); chk("model_hang", 32'(r), R_ERR);
        p_err = tr.size();
        gen_term(3, 0, 1, 1);

        // rst in EXEC of add
        gen_reset();
        mem[0] = 9'h080;
        gen_idle(1, 1, 0);
        r = gen_instr(3, 0, 0, 2); chk("model_abort", 32'(r), R_ABORT);
        p_rst = tr.size();
        gen_idle(2, 0, 0);

        // run through the whole address space to the PC wrap
        gen_reset();
        for (int a = 0; a < DEPTH; a++)
            mem[a] = (a % 2 == 1) ? {3'b101, 6'(a)} : {3'b000, 6'(a)};
        gen_idle(1, 1, 0);
        for (int a = 0; a < DEPTH; a++) r = gen_instr(1, 0, 0, 0);
        p_wrap = tr.size();
`ifdef PROGRAM_SEQUENCER_HALT_ON_WRAP_EN
        chk("model_wrap", 32'(r), R_HALT);
`else
        chk("model_wrap", 32'(r), R_NEXT);
`endif
        if (r == R_HALT) begin
            gen_term(2, 1, 1, 0);
        end else begin
            r = gen_instr(1, 0, 0, 0);
            gen_reset();
        end
        gen_idle(1, 0, 0);

        chk("model_first_rd", 32'(tr[p_s1 + 1].rd), 32'd1);
        chk("model_mv_din",   32'(tr[p_s1 + 3].din), 32'h00A);
        chk("model_mvi_imm",  32'(tr[p_mvi + 5].din), 32'h05A);

        for (int i = 0; i < tr.size(); i++) begin
            @(posedge clk);
            #1;
            rst = tr[i].rst; start = tr[i].start; stop = tr[i].stop;
            proc_done = tr[i].done; mem_data = tr[i].mdata;
            cur = i;
            cmp_en = 1'b1;
            if (i == p_s1 + 1) chk("lit_first_rd", 32'(mem_rd), 32'd1);
            if (i == p_s1 + 3) begin
                chk("lit_mv_run", 32'(proc_run), 32'd1);
                chk("lit_mv_din", 32'(proc_din), 32'h00A);
            end
            if (i == p_s1 + 5) chk("lit_pc_after_mv", 32'(pc), 32'd1);
            if (i == p_halt) begin
                chk("lit_halted", 32'(halted), 32'd1);
                chk("lit_halt_pc", 32'(pc), 32'd3);
            end
            if (i == p_mvi + 4) chk("lit_mvi_issue", 32'(proc_din), 32'h040);
            if (i == p_mvi + 5) chk("lit_mvi_exec", 32'(proc_din), 32'h05A);
            if (i == p_mvi + 6) chk("lit_mvi_pc", 32'(pc), 32'd2);
            if (i == p_err) begin
                chk("lit_error", 32'(error), 32'd1);
                chk("lit_error_busy", 32'(busy), 32'd0);
                chk("lit_error_pc", 32'(pc), 32'd6);
            end
            if (i == p_rst) begin
                chk("lit_rst_pc", 32'(pc), 32'd0);
                chk("lit_rst_busy", 32'(busy), 32'd0);
            end
            if (i == p_wrap) begin
`ifdef PROGRAM_SEQUENCER_HALT_ON_WRAP_EN
                chk("lit_wrap_halted", 32'(halted), 32'd1);
`else
                chk("lit_wrap_rd", 32'(mem_rd), 32'd1);
`endif
                chk("lit_wrap_addr", 32'(mem_addr), 32'd0);
            end
        end
        @(negedge clk);
        #1;
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter INSTRUCTION_WIDTH, default 9, instruction/immediate word width.
REQ-002 Parameter ADDR_WIDTH, default 5, program-memory address and PC width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  level; begin or resume fetching from current PC while IDLE.
REQ-006 stop  input  1  level; request return to IDLE at next instruction boundary.
REQ-007 mem_rd  output  1  program-memory read strobe.
REQ-008 mem_addr  output  ADDR_WIDTH  read address; always equals pc.
REQ-009 mem_data  input  INSTRUCTION_WIDTH  read data, valid exactly one cycle after mem_rd.
REQ-010 proc_din  output  INSTRUCTION_WIDTH  word driven to the processor's din.
REQ-011 proc_run  output  1  processor run request.
REQ-012 proc_done  input  1  processor instruction-complete pulse.
REQ-013 pc  output  ADDR_WIDTH  program counter.
REQ-014 busy, halted, error  output  1 each  status flags.

Function
REQ-015 Opcode field is word[8:6]: 000 mv, 001 mvi, 010 add, 011 sub, 111 HALT (consumed internally, never issued); 100-110 are issued like mv.
REQ-016 States: IDLE, FETCH_OP, LATCH_OP, FETCH_IMM, LATCH_IMM, ISSUE, EXEC, HALTED, ERROR.
REQ-017 IDLE: start=1 and stop=0 -> FETCH_OP; stop=1 wins over start (stays in IDLE).
REQ-018 FETCH_OP and FETCH_IMM: mem_rd=1 for exactly one cycle; mem_rd=0 in all other states.
REQ-019 LATCH_OP: op_reg<=mem_data, pc<=pc+1; next state HALTED if HALT, FETCH_IMM if mvi, else ISSUE.
REQ-020 LATCH_IMM: imm_reg<=mem_data, pc<=pc+1; next state ISSUE.
REQ-021 ISSUE: one cycle, proc_run=1, proc_din=op_reg; next state EXEC.
REQ-022 EXEC: proc_run=0; proc_din=imm_reg if op is mvi, else 0; 3-bit timeout counter cleared on entry, incremented each EXEC cycle.
REQ-023 EXEC, proc_done=1: stop=1 -> IDLE, else FETCH_OP; proc_done takes priority over the timeout.
REQ-024 EXEC, 4 cycles without proc_done -> ERROR; mv/mvi complete on the 1st EXEC cycle, add/sub on the 3rd.
REQ-025 proc_done outside EXEC is ignored.
REQ-026 proc_din=0 in every state except ISSUE and mvi-EXEC.
REQ-027 PC arithmetic modulo 2^ADDR_WIDTH; all-ones+1 = 0.
REQ-028 stop is sampled only in IDLE and at EXEC completion; the in-flight instruction always completes.
REQ-029 busy=1 in FETCH_OP..EXEC; halted=1 only in HALTED; error=1 only in ERROR.
REQ-030 HALTED and ERROR are terminal; start and stop are ignored; exit only via rst.
REQ-031 Fetch-to-issue latency: ISSUE occurs 2 cycles after FETCH_OP entry (4 for mvi).

Reset
REQ-032 rst=1 at any clock edge, including mid-instruction: state IDLE, pc=0, op_reg=0, imm_reg=0, timeout=0, wrap flag=0.
REQ-033 Outputs while in reset and the cycle after: mem_rd=0, proc_run=0, proc_din=0, busy=0, halted=0, error=0, mem_addr=0.

Configuration
REQ-034 Macro PROGRAM_SEQUENCER_HALT_ON_WRAP_EN.
REQ-035 Defined: any PC increment from all-ones to 0 sets the wrap flag; the next EXEC completion goes to HALTED (overrides stop and FETCH_OP); if the wrap occurs in LATCH_OP on a HALT word, the sequencer goes to HALTED directly.
REQ-036 Undefined: no wrap flag; PC wraps silently and fetching continues from address 0.

Verification
REQ-037 mem[0]=mv(000_001_010), start 1 cycle: mem_rd at cycle 1, ISSUE proc_run=1, proc_din=0x00A at cycle 3, done in EXEC -> FETCH_OP with pc=1.
REQ-038 mem[0]=mvi R0(001_000_000), mem[1]=0x05A: proc_din=0x040 in ISSUE, 0x05A in EXEC, pc=2 after.
REQ-039 add with done on 3rd EXEC cycle -> FETCH_OP; no done for 4 EXEC cycles -> error=1, busy=0, holds until rst.
REQ-040 mem[2]=HALT(111_000_000) after two mv: halted=1, pc=3, proc_run never asserted for HALT; start ignored.
REQ-041 stop raised in ISSUE of add: instruction completes, IDLE after done; start and stop together in IDLE -> stays IDLE; rst in EXEC -> IDLE, pc=0 next cycle.
REQ-042 ADDR_WIDTH=2, four mv words: with macro halted=1 after the word at address 3; without macro, fetch resumes at address 0.
